stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Four-digit decade stopwatch controller that sequences the chain of mod-10 digit counters used on the board displays. It prescales `clk` into a count tick, runs a start/pause/clear state machine from push-button inputs, and ripples carries through four BCD digits. It also provides a lap (display freeze) function, and its digit outputs feed the seven-segment decoders directly.

## Interface
- `PRESCALE`, default 500000: `clk` cycles per count tick (10 ms at 50 MHz); minimum value 2.
- `clk`  input  1  system clock, rising-edge active.
- `rst`  input  1  asynchronous, active-low reset.
- `start_stop`  input  1  active-high level, synchronous to `clk`; each rising edge toggles run/pause.
- `clear`  input  1  active-high level, synchronous; a rising edge zeroes the count when the block is not running.
- `lap`  input  1  active-high level, synchronous; a rising edge toggles the display freeze.
- `dig0`..`dig3`  output  4 each  displayed BCD digits; `dig0` is least significant. Each holds 0..9.
- `running`  output  1  high in RUN.
- `frozen`  output  1  high while the display shows a lap snapshot.
- `overflow`  output  1  sticky; set when the count wraps from 9999 to 0000.
- `tick`  output  1  one-cycle count-enable pulse.

## Operation
- **Edge detect:** one `prev` register per button. Edge = `in & ~prev`. All `prev` registers reset to 1, so a button held through reset release generates no edge.
- **FSM states:** IDLE, RUN, PAUSE. Reset state is IDLE.
- **Priority each cycle:** `clear` is evaluated first, then `start_stop`, then `lap`.
- **IDLE:**
  - `start_stop` edge goes to RUN.
  - `clear` edge stays in IDLE and re-zeroes the count, prescaler, `overflow` and `frozen`.
- **RUN:**
  - `clear` edge is ignored.
  - `start_stop` edge goes to PAUSE.
  - `lap` edge toggles `frozen`. Setting `frozen` copies the live digits into the snapshot on the same edge.
- **PAUSE:**
  - `clear` edge goes to IDLE and zeroes the count, prescaler, `overflow` and `frozen`. A `start_stop` edge in the same cycle is discarded.
  - `start_stop` edge alone goes to RUN.
  - `lap` edge clears `frozen`; it never sets it.
- **Prescaler:**
  - Counts 0..PRESCALE-1 and advances only in RUN.
  - Holds its value in PAUSE, so the fractional tick is preserved across a pause.
  - Zeroed on every entry to IDLE.
- **tick:** combinational; `tick = (state==RUN) && (pre==PRESCALE-1)`. At that edge `pre` wraps to 0.
- **Digit chain on tick:**
  - `dig0` increments.
  - Digit n wraps 9→0 and carries into digit n+1 in the same edge (full ripple, no added latency).
  - 9999→0000 sets `overflow`; counting continues.
- **Display:** `dig0`..`dig3` show the live digits when `frozen`=0 and the snapshot when `frozen`=1. The live count keeps running while frozen.
- **Widths:** the internal digits are 4 bits and never hold 10..15. `pre` is `$clog2(PRESCALE)` bits.

## Timing
- **Reset (asynchronous, `rst`=0):**
  - Takes effect immediately regardless of `clk`.
  - All outputs are 0: digits 0, `running`=0, `frozen`=0, `overflow`=0, `tick`=0.
  - State goes to IDLE, `pre`=0, `prev`=1.
  - Reset mid-run discards the count and snapshot.
- **Button latency:**
  - A button rising before edge E is registered into `prev` at E. The edge term is high during the following cycle, and the state/flag change lands at edge E+1.
  - `running` goes high after E+1.
- **First tick:** the first `tick` after entering RUN from IDLE is high in the PRESCALE-th cycle in RUN. Digits read 0001 after that edge.
- **Stop timing:** a stop edge landing on the same edge as a tick still applies that tick's increment.
- **No repeat:** a held button produces exactly one edge.

## Test plan
1. **Reset:** assert `rst`=0 mid-run with digits at 0347 → all outputs 0 immediately. After release, `running` stays 0 until a fresh `start_stop` edge.
2. **Basic count (PRESCALE=4):** start pulse, then 40 cycles in RUN → exactly 10 `tick` pulses; digits read 0010; `dig0` wraps 9→0 with `dig1` 0→1 on the same edge.
3. **Pause/resume:** stop 2 cycles after a tick, wait 20 cycles → digits and `pre` unchanged, `tick` stays 0. Resume → next tick after exactly 2 more RUN cycles.
4. **Wrap:** preload by running 9999 ticks, then one more → digits 0000, `overflow`=1, `running`=1. A `clear` edge in PAUSE then zeroes `overflow`.
5. **Lap:** `lap` edge in RUN at count 0123, run 8 more ticks → display holds 0123 with `frozen`=1. Second `lap` edge → display shows live 0131.
6. **Priority:**
   - `clear` edge in RUN → ignored, count continues.
   - `clear` and `start_stop` rising on the same cycle in PAUSE → IDLE, digits 0000, `running`=0.
   - Button held high through reset release → no state change.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Purpose : four-digit BCD stopwatch; prescaled count tick, start/pause/clear FSM, lap freeze.
// Latency : button edge acts two edges after the input rises; digits update on the tick edge.
// Backpr. : none; buttons are levels, each rising edge is consumed exactly once.
// Ports   : clk, rst (async active-low); start_stop/clear/lap button levels;
//           dig0..dig3 displayed BCD digits (dig0 least significant); running, frozen,
//           overflow (sticky on 9999->0000 wrap), tick (count-enable pulse, combinational).
module stopwatch_ctrl #(
   parameter int PRESCALE = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] dig0,
   output logic [3:0] dig1,
   output logic [3:0] dig2,
   output logic [3:0] dig3,
   output logic       running,
   output logic       frozen,
   output logic       overflow,
   output logic       tick
);

   localparam int            PW      = $clog2(PRESCALE);
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t          state;
   logic [PW-1:0]   pre;
   logic [3:0][3:0] cnt;
   logic [3:0][3:0] cnt_nxt;
   logic [3:0][3:0] snap;
   logic            carry;
   logic            wrap;

   // prev registers reset high so a button held through reset release is not an edge
   logic ss_prev, clr_prev, lap_prev;
   // registered edge pulses: high for the cycle after the input was sampled
   logic ss_edge, clr_edge, lap_edge;

   assign tick = (state == RUN) && (pre == PRE_MAX);

   // full ripple: every digit sees its carry in the same edge as the tick
   always_comb begin
      cnt_nxt = cnt;
      carry   = tick;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (cnt[i] == 4'd9) begin
               cnt_nxt[i] = 4'd0;
            end else begin
               cnt_nxt[i] = cnt[i] + 4'd1;
               carry      = 1'b0;
            end
         end
      end
      wrap = carry;
   end

   assign dig0 = frozen ? snap[0] : cnt[0];
   assign dig1 = frozen ? snap[1] : cnt[1];
   assign dig2 = frozen ? snap[2] : cnt[2];
   assign dig3 = frozen ? snap[3] : cnt[3];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         running  <= 1'b0;
         frozen   <= 1'b0;
         overflow <= 1'b0;
         pre      <= '0;
         cnt      <= '0;
         snap     <= '0;
         ss_prev  <= 1'b1;
         clr_prev <= 1'b1;
         lap_prev <= 1'b1;
         ss_edge  <= 1'b0;
         clr_edge <= 1'b0;
         lap_edge <= 1'b0;
      end else begin
         ss_prev  <= start_stop;
         clr_prev <= clear;
         lap_prev <= lap;
         ss_edge  <= start_stop & ~ss_prev;
         clr_edge <= clear & ~clr_prev;
         lap_edge <= lap & ~lap_prev;

         case (state)
            IDLE: begin
               // clear consumes the cycle; a simultaneous start is dropped
               if (clr_edge) begin
                  cnt      <= '0;
                  pre      <= '0;
                  overflow <= 1'b0;
                  frozen   <= 1'b0;
               end else if (ss_edge) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               pre <= tick ? '0 : pre + 1'b1;
               cnt <= cnt_nxt;
               if (wrap) overflow <= 1'b1;
               // stop on a tick edge still takes that tick's increment above
               if (ss_edge) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end
               if (lap_edge) begin
                  frozen <= ~frozen;
                  if (!frozen) snap <= cnt;
               end
            end
            PAUSE: begin
               // pre is left alone so the partial tick survives the pause
               if (clr_edge) begin
                  state    <= IDLE;
                  running  <= 1'b0;
                  cnt      <= '0;
                  pre      <= '0;
                  overflow <= 1'b0;
                  frozen   <= 1'b0;
               end else begin
                  if (ss_edge) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
                  if (lap_edge) frozen <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Stopwatch controller bench: expectations are queued against a cycle number,
// a monitor on the falling edge pops and compares them when that cycle arrives.
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_stop;
   logic       clear;
   logic       lap;
   logic [3:0] dig0, dig1, dig2, dig3;
   logic       running, frozen, overflow, tick;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int tick_total = 0;

   typedef struct {
      int         cyc;
      logic [15:0] digs;
      logic [3:0]  flags;   // {running, frozen, overflow, tick}
      int         ticks;   // cumulative tick pulses, -1 = not checked
   } exp_t;

   exp_t  q[$];
   string nq[$];

   stopwatch_ctrl #(.PRESCALE(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_stop (start_stop),
      .clear      (clear),
      .lap        (lap),
      .dig0       (dig0),
      .dig1       (dig1),
      .dig2       (dig2),
      .dig3       (dig3),
      .running    (running),
      .frozen     (frozen),
      .overflow   (overflow),
      .tick       (tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor / scoreboard
   always @(negedge clk) begin
      exp_t        e;
      string       nm;
      logic [15:0] act_d;
      logic [3:0]  act_f;
      if (tick === 1'b1) tick_total++;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e     = q.pop_front();
         nm    = nq.pop_front();
         act_d = {dig3, dig2, dig1, dig0};
         act_f = {running, frozen, overflow, tick};
         checks++;
         if (act_d !== e.digs) begin
            errors++;
            $display("FAIL %s digits: got %h want %h (cycle %0d)", nm, act_d, e.digs, cyc);
         end
         checks++;
         if (act_f !== e.flags) begin
            errors++;
            $display("FAIL %s flags{run,frz,ovf,tick}: got %b want %b (cycle %0d)", nm, act_f, e.flags, cyc);
         end
         if (e.ticks >= 0) begin
            checks++;
            if (tick_total != e.ticks) begin
               errors++;
               $display("FAIL %s tick count: got %0d want %0d", nm, tick_total, e.ticks);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [15:0] digs,
                             input logic [3:0] flags, input int ticks);
      exp_t e;
      e.cyc   = cyc;
      e.digs  = digs;
      e.flags = flags;
      e.ticks = ticks;
      q.push_back(e);
      nq.push_back(name);
   endtask

   // 0 = start_stop, 1 = clear, 2 = lap; one-cycle pulse
   task automatic press(input int b);
      case (b)
         0: start_stop = 1'b1;
         1: clear      = 1'b1;
         default: lap  = 1'b1;
      endcase
      step(1);
      start_stop = 1'b0;
      clear      = 1'b0;
      lap        = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
      step(2);
      expect_out("reset_init", 16'h0000, 4'b0000, 0);
      rst = 1'b1;
      step(2);
      expect_out("idle_after_reset", 16'h0000, 4'b0000, -1);

      // basic count: first tick in 4th RUN cycle, 10 ticks in 40 cycles
      press(0); step(1);
      expect_out("run_entry", 16'h0000, 4'b1000, -1);
      step(39);
      expect_out("tenth_tick", 16'h0009, 4'b1001, -1);
      step(1);
      expect_out("carry_dig1", 16'h0010, 4'b1000, 10);

      // pause two cycles after the tick, hold, resume
      press(0);
      expect_out("stop_pending", 16'h0010, 4'b1000, -1);
      step(1);
      expect_out("paused", 16'h0010, 4'b0000, -1);
      step(20);
      expect_out("pause_hold", 16'h0010, 4'b0000, 10);
      press(0);
      step(1);
      expect_out("resume_pre2", 16'h0010, 4'b1000, -1);
      step(1);
      expect_out("resume_tick", 16'h0010, 4'b1001, -1);
      step(1);
      expect_out("resume_inc", 16'h0011, 4'b1000, -1);

      // lap freeze at 0123, eight more ticks, release shows live 0131
      step(448);
      expect_out("count_0123", 16'h0123, 4'b1000, -1);
      press(2);
      step(1);
      expect_out("lap_frozen", 16'h0123, 4'b1100, -1);
      step(30);
      expect_out("lap_hold", 16'h0123, 4'b1100, 131);
      press(2);
      step(1);
      expect_out("lap_release", 16'h0131, 4'b1000, -1);

      // clear in RUN ignored
      press(1);
      step(1);
      expect_out("clear_in_run_ignored", 16'h0132, 4'b1000, 132);

      // clear and start together in PAUSE -> IDLE
      press(0);
      step(1);
      expect_out("paused2", 16'h0132, 4'b0000, -1);
      start_stop = 1'b1; clear = 1'b1;
      step(1);
      start_stop = 1'b0; clear = 1'b0;
      step(1);
      expect_out("clear_beats_start", 16'h0000, 4'b0000, -1);

      // wrap 9999 -> 0000
      press(0); step(1);
      step(3);
      expect_out("first_tick", 16'h0000, 4'b1001, -1);
      step(39993);
      expect_out("at_9999", 16'h9999, 4'b1000, -1);
      step(3);
      expect_out("wrap_tick", 16'h9999, 4'b1001, -1);
      step(1);
      expect_out("wrapped", 16'h0000, 4'b1010, -1);
      press(0);
      step(1);
      expect_out("paused_ovf", 16'h0000, 4'b0010, -1);
      press(1);
      step(1);
      expect_out("clear_ovf", 16'h0000, 4'b0000, 10132);

      // reset mid-run with a snapshot held at 0347
      press(0); step(1);
      step(1388);
      expect_out("count_0347", 16'h0347, 4'b1000, -1);
      press(2);
      step(1);
      expect_out("snap_0347", 16'h0347, 4'b1100, 10479);
      step(1);
      start_stop = 1'b1;
      rst = 1'b0;
      expect_out("reset_async", 16'h0000, 4'b0000, -1);
      step(2);
      rst = 1'b1;
      step(5);
      expect_out("held_through_reset", 16'h0000, 4'b0000, -1);
      start_stop = 1'b0;
      step(3);
      expect_out("no_edge_on_release", 16'h0000, 4'b0000, -1);
      press(0); step(1);
      expect_out("fresh_start", 16'h0000, 4'b1000, -1);
      step(2);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_expectations: got %0d left want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
